// File: rtl/fib_sched_if.sv
// Request/result bundle for fib_sched.
// master: requesters and result consumer side; slave: the engine.
interface fib_sched_if #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned IDX_W = 7
);
  logic             req0_valid;
  logic [IDX_W-1:0] req0_idx;
  logic             req0_ready;
  logic             req1_valid;
  logic [IDX_W-1:0] req1_idx;
  logic             req1_ready;
  logic             res_valid;
  logic [WIDTH-1:0] res_data;
  logic             res_ovf;
  logic             res_id;
  logic             res_ready;
  logic             busy;

  modport master (
    output req0_valid, req0_idx, req1_valid, req1_idx, res_ready,
    input  req0_ready, req1_ready, res_valid, res_data, res_ovf, res_id, busy
  );

  modport slave (
    input  req0_valid, req0_idx, req1_valid, req1_idx, res_ready,
    output req0_ready, req1_ready, res_valid, res_data, res_ovf, res_id, busy
  );
endinterface

// File: rtl/fib_sched.sv
// Shared Fibonacci engine with a two-requester round-robin front end.
// One prev/cur register pair is stepped once per clock; results carry the
// requester id and a sticky overflow flag.
// Optional macro FIB_SAT_EN: saturate res_data to all ones on overflow
// (default build returns F(N) mod 2^WIDTH).
module fib_sched #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned IDX_W = 7
) (
  input  logic        clk,
  input  logic        rst,
  fib_sched_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] prev;
  logic [WIDTH-1:0] cur;
  logic             prev_flag;
  logic             cur_flag;
  logic [IDX_W-1:0] cnt;
  logic             id;
  logic             last_id;

  logic             res_valid_q;
  logic [WIDTH-1:0] res_data_q;
  logic             res_ovf_q;
  logic             res_id_q;
  logic             busy_q;

  logic             grant0_c;
  logic             grant1_c;
  logic [IDX_W-1:0] grant_idx_c;
  logic [WIDTH:0]   sum_c;
  logic [WIDTH-1:0] final_data_c;

  // Round-robin grant in IDLE; a tie goes to the requester not served last.
  always_comb begin
    grant0_c = 1'b0;
    grant1_c = 1'b0;
    if (state == IDLE) begin
      if (bus.req0_valid && bus.req1_valid) begin
        grant0_c = last_id;
        grant1_c = ~last_id;
      end else begin
        grant0_c = bus.req0_valid;
        grant1_c = bus.req1_valid;
      end
    end
  end

  // Index of whichever requester is granted.
  always_comb begin
    grant_idx_c = grant1_c ? bus.req1_idx : bus.req0_idx;
  end

  // One recurrence step with carry out for overflow tracking.
  always_comb begin
    sum_c = {1'b0, prev} + {1'b0, cur};
  end

  // Value published when the last step lands: cur becomes prev = F(N).
`ifdef FIB_SAT_EN
  always_comb begin
    final_data_c = cur_flag ? {WIDTH{1'b1}} : cur;
  end
`else
  always_comb begin
    final_data_c = cur;
  end
`endif

  // Control FSM, datapath and registered result outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= IDLE;
      prev        <= '0;
      cur         <= WIDTH'(1);
      prev_flag   <= 1'b0;
      cur_flag    <= 1'b0;
      cnt         <= '0;
      id          <= 1'b0;
      last_id     <= 1'b1;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_ovf_q   <= 1'b0;
      res_id_q    <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant0_c || grant1_c) begin
            prev      <= '0;
            cur       <= WIDTH'(1);
            prev_flag <= 1'b0;
            cur_flag  <= 1'b0;
            cnt       <= grant_idx_c;
            id        <= grant1_c;
            last_id   <= grant1_c;
            busy_q    <= 1'b1;
            if (grant_idx_c == '0) begin
              // F(0) is ready immediately.
              state       <= DONE;
              res_valid_q <= 1'b1;
              res_data_q  <= '0;
              res_ovf_q   <= 1'b0;
              res_id_q    <= grant1_c;
            end else begin
              state <= RUN;
            end
          end
        end
        RUN: begin
          prev      <= cur;
          cur       <= sum_c[WIDTH-1:0];
          prev_flag <= cur_flag;
          cur_flag  <= sum_c[WIDTH] | prev_flag | cur_flag;
          cnt       <= cnt - IDX_W'(1);
          if (cnt == IDX_W'(1)) begin
            state       <= DONE;
            res_valid_q <= 1'b1;
            res_data_q  <= final_data_c;
            res_ovf_q   <= cur_flag;
            res_id_q    <= id;
          end
        end
        DONE: begin
          if (bus.res_ready) begin
            state       <= IDLE;
            res_valid_q <= 1'b0;
            busy_q      <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.req0_ready = grant0_c;
  assign bus.req1_ready = grant1_c;
  assign bus.res_valid  = res_valid_q;
  assign bus.res_data   = res_data_q;
  assign bus.res_ovf    = res_ovf_q;
  assign bus.res_id     = res_id_q;
  assign bus.busy       = busy_q;

endmodule

// File: tb/tb_fib_sched.sv
// Directed bench for fib_sched: reset, basic results, width boundary,
// arbitration, backpressure and mid-run reset.
module tb_fib_sched;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;

  fib_sched_if #(.WIDTH(32), .IDX_W(7)) bus ();

  fib_sched #(.WIDTH(32), .IDX_W(7)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
  endtask

  // Wait (bounded) for res_valid; lat counts edges since the accept edge.
  task automatic wait_res(output int lat);
    lat = 0;
    while (bus.res_valid !== 1'b1 && lat < 300) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic handshake();
    bus.res_ready = 1'b1;
    @(negedge clk);
    bus.res_ready = 1'b0;
  endtask

  // Issue one request from a single requester and check the full result.
  task automatic run_req(input bit sel, input int n, input logic [31:0] exp_data,
                         input bit exp_ovf, input string tag);
    int lat;
    @(negedge clk);
    if (sel) begin
      bus.req1_valid = 1'b1;
      bus.req1_idx   = 7'(n);
    end else begin
      bus.req0_valid = 1'b1;
      bus.req0_idx   = 7'(n);
    end
    #1;
    check({tag, "_ready"}, sel ? bus.req1_ready : bus.req0_ready, 1);
    @(negedge clk);
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    wait_res(lat);
    check({tag, "_lat"},  lat, n);
    check({tag, "_data"}, bus.res_data, exp_data);
    check({tag, "_ovf"},  bus.res_ovf, exp_ovf);
    check({tag, "_id"},   bus.res_id, sel);
    check({tag, "_busy"}, bus.busy, 1);
    handshake();
    check({tag, "_post_valid"}, bus.res_valid, 0);
    check({tag, "_post_busy"},  bus.busy, 0);
  endtask

  initial begin
    int   lat;
    int   seen;
    int   cyc;
    int   last_cyc;
    bit   ok;
    logic [31:0] exp48;

    n_cmp = 0;
    n_err = 0;
    rst = 1'b0;
    bus.req0_valid = 1'b0;
    bus.req0_idx   = '0;
    bus.req1_valid = 1'b0;
    bus.req1_idx   = '0;
    bus.res_ready  = 1'b0;

    // Reset held 3 cycles
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_res_valid", bus.res_valid, 0);
    check("rst_busy",      bus.busy, 0);
    check("rst_res_data",  bus.res_data, 0);
    check("rst_res_id",    bus.res_id, 0);
    rst = 1'b1;
    @(negedge clk);
    check("idle_ready0_no_valid", bus.req0_ready, 0);

    // Basic results
    run_req(0, 10, 32'd55, 0, "n10");
    run_req(1, 0,  32'd0,  0, "n0");
    run_req(0, 1,  32'd1,  0, "n1");

    // Width boundary
    run_req(1, 47, 32'd2971215073, 0, "n47");
`ifdef FIB_SAT_EN
    exp48 = 32'hFFFF_FFFF;
`else
    exp48 = 32'd512559680;
`endif
    run_req(0, 48, exp48, 1, "n48");

    // Backpressure: hold DONE 20 cycles with both requesters waiting
    @(negedge clk);
    bus.req0_valid = 1'b1;
    bus.req0_idx   = 7'd4;
    @(negedge clk);
    bus.req0_valid = 1'b0;
    wait_res(lat);
    check("bp_lat",  lat, 4);
    check("bp_data", bus.res_data, 3);
    bus.req0_valid = 1'b1;
    bus.req0_idx   = 7'd2;
    bus.req1_valid = 1'b1;
    bus.req1_idx   = 7'd2;
    ok = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (bus.res_valid !== 1'b1 || bus.res_data !== 32'd3 || bus.res_id !== 1'b0 ||
          bus.res_ovf !== 1'b0 || bus.req0_ready !== 1'b0 || bus.req1_ready !== 1'b0 ||
          bus.busy !== 1'b1)
        ok = 1'b0;
    end
    check("bp_stable", ok, 1);
    handshake();
    check("bp_idle_ready1", bus.req1_ready, 1);
    check("bp_idle_ready0", bus.req0_ready, 0);
    @(negedge clk);
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    check("bp_next_busy", bus.busy, 1);
    wait_res(lat);
    check("bp_next_lat",  lat, 2);
    check("bp_next_data", bus.res_data, 1);
    check("bp_next_id",   bus.res_id, 1);
    handshake();

    // Arbitration: both valid continuously, fresh reset so req0 wins first
    do_reset();
    bus.req0_idx   = 7'd3;
    bus.req1_idx   = 7'd5;
    bus.req0_valid = 1'b1;
    bus.req1_valid = 1'b1;
    bus.res_ready  = 1'b1;
    seen = 0;
    cyc = 0;
    last_cyc = 0;
    while (seen < 4 && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (bus.res_valid === 1'b1) begin
        check($sformatf("arb%0d_id", seen),   bus.res_id, seen % 2);
        check($sformatf("arb%0d_data", seen), bus.res_data, (seen % 2) ? 5 : 2);
        if (seen > 0)
          check($sformatf("arb%0d_gap", seen), cyc - last_cyc, (seen % 2) ? 7 : 5);
        last_cyc = cyc;
        seen++;
      end
    end
    check("arb_count", seen, 4);
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    @(negedge clk);
    bus.res_ready = 1'b0;
    check("arb_end_busy", bus.busy, 0);

    // Reset during the 4th RUN cycle of N=20
    @(negedge clk);
    bus.req0_valid = 1'b1;
    bus.req0_idx   = 7'd20;
    @(negedge clk);
    bus.req0_valid = 1'b0;
    check("mr_busy_run", bus.busy, 1);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    check("mr_busy_after", bus.busy, 0);
    check("mr_valid_after", bus.res_valid, 0);
    ok = 1'b1;
    repeat (30) begin
      @(negedge clk);
      if (bus.res_valid !== 1'b0 || bus.busy !== 1'b0) ok = 1'b0;
    end
    check("mr_no_result", ok, 1);
    run_req(0, 6, 32'd8, 0, "mr_n6");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
